// File: rtl/alu_issue_buf.sv
// Two-entry skid buffer between decode and the ALU: registered outputs, registered
// in_ready, one-hot aluop check carried with each entry, saturating stall counter.
module alu_issue_buf #(
  parameter int XLEN = 64,
  parameter int OPW  = 2,
  parameter int TAGW = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [OPW-1:0]  in_aluop,
  input  logic [TAGW-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [OPW-1:0]  out_aluop,
  output logic [TAGW-1:0] out_rd,
  output logic            out_illegal,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic w_push;
  logic w_pop;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;
  logic w_in_illegal;

  logic [XLEN-1:0] r_main_src1, r_main_src2, r_skid_src1, r_skid_src2;
  logic [OPW-1:0]  r_main_aluop, r_skid_aluop;
  logic [TAGW-1:0] r_main_rd, r_skid_rd;
  logic            r_main_illegal, r_skid_illegal;
  logic [CNTW-1:0] r_stall_cnt;

  // Both handshake outputs depend only on registered state, so neither
  // in->out nor out_ready->in_ready has a combinational path.
  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // The ALU decodes aluop as one-hot (bit0=add, bit1=sltu); anything else is flagged.
  assign w_in_illegal = !$onehot(in_aluop);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of the order in which blocks are evaluated.
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that leaves
    // one unassigned would infer a latch.
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_nxt    = ST_ONE;
            w_load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          unique case ({w_push, w_pop})
            2'b11: w_load_main_in = 1'b1;
            2'b10: begin
              w_state_nxt = ST_TWO;
              w_load_skid = 1'b1;
            end
            2'b01: w_state_nxt = ST_EMPTY;
            default: w_state_nxt = ST_ONE;
          endcase
        end
        ST_TWO: begin
          if (w_pop) begin
            w_state_nxt      = ST_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // NOTE: payload registers are only a two-deep store, so they take the async
  // reset like the control; a larger payload RAM would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_src1    <= '0;
      r_main_src2    <= '0;
      r_main_aluop   <= '0;
      r_main_rd      <= '0;
      r_main_illegal <= 1'b0;
    end else if (w_load_main_in) begin
      r_main_src1    <= in_src1;
      r_main_src2    <= in_src2;
      r_main_aluop   <= in_aluop;
      r_main_rd      <= in_rd;
      r_main_illegal <= w_in_illegal;
    end else if (w_load_main_skid) begin
      r_main_src1    <= r_skid_src1;
      r_main_src2    <= r_skid_src2;
      r_main_aluop   <= r_skid_aluop;
      r_main_rd      <= r_skid_rd;
      r_main_illegal <= r_skid_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_src1    <= '0;
      r_skid_src2    <= '0;
      r_skid_aluop   <= '0;
      r_skid_rd      <= '0;
      r_skid_illegal <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_src1    <= in_src1;
      r_skid_src2    <= in_src2;
      r_skid_aluop   <= in_aluop;
      r_skid_rd      <= in_rd;
      r_skid_illegal <= w_in_illegal;
    end
  end

  // Counts on registered out_valid, so a flush cycle that stalls still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != {CNTW{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNTW'(1);
    end
  end

  assign out_src1    = r_main_src1;
  assign out_src2    = r_main_src2;
  assign out_aluop   = r_main_aluop;
  assign out_rd      = r_main_rd;
  assign out_illegal = r_main_illegal;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_alu_issue_buf.sv
// Directed bench for alu_issue_buf: a default build plus a CNTW=4 build that shares
// its stimulus, used for the counter saturation case.
module tb_alu_issue_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_src1 = '0;
  logic [63:0] in_src2 = '0;
  logic [1:0]  in_aluop = '0;
  logic [4:0]  in_rd = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_illegal;
  logic [63:0] out_src1, out_src2;
  logic [1:0]  out_aluop;
  logic [4:0]  out_rd;
  logic [31:0] stall_cnt;

  logic        in_ready4, out_valid4, out_illegal4;
  logic [63:0] out_src1_4, out_src2_4;
  logic [1:0]  out_aluop4;
  logic [4:0]  out_rd4;
  logic [3:0]  stall_cnt4;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  alu_issue_buf dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_aluop(in_aluop), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src1(out_src1), .out_src2(out_src2), .out_aluop(out_aluop), .out_rd(out_rd),
    .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  alu_issue_buf #(.CNTW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_src1(in_src1), .in_src2(in_src2), .in_aluop(in_aluop), .in_rd(in_rd),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_src1(out_src1_4), .out_src2(out_src2_4), .out_aluop(out_aluop4), .out_rd(out_rd4),
    .out_illegal(out_illegal4), .stall_cnt(stall_cnt4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive(input logic [63:0] s1, input logic [63:0] s2,
                       input logic [1:0] op, input logic [4:0] rd);
    in_valid = 1'b1;
    in_src1  = s1;
    in_src2  = s2;
    in_aluop = op;
    in_rd    = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset state and single push with one-cycle latency
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_stall", stall_cnt, 0);
    check("rst_src1", out_src1, 0);
    out_ready = 1'b1;
    drive(5, 7, 2'b01, 3);
    step();
    in_valid = 1'b0;
    check("t1_valid", out_valid, 1);
    check("t1_src1", out_src1, 5);
    check("t1_src2", out_src2, 7);
    check("t1_rd", out_rd, 3);
    check("t1_aluop", out_aluop, 2'b01);
    check("t1_illegal", out_illegal, 0);
    step();
    check("t1_drained", out_valid, 0);

    // 2: backpressure fills both entries, drain preserves order
    do_reset();
    drive(64'hA1, 64'hA2, 2'b01, 10);
    step();
    check("t2_ready_one", in_ready, 1);
    check("t2_head_a", out_src1, 64'hA1);
    drive(64'hB1, 64'hB2, 2'b10, 11);
    step();
    in_valid = 1'b0;
    check("t2_ready_two", in_ready, 0);
    check("t2_hold_a", out_src1, 64'hA1);
    step();
    check("t2_still_a", out_rd, 10);
    check("t2_stall2", stall_cnt, 2);
    out_ready = 1'b1;
    step();
    check("t2_head_b", out_src1, 64'hB1);
    check("t2_rd_b", out_rd, 11);
    check("t2_ready_after_a", in_ready, 1);
    check("t2_stall_hold", stall_cnt, 2);
    step();
    check("t2_empty", out_valid, 0);

    // 3: streaming, one op per cycle
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(64'd100 + 64'(i), 64'd200 + 64'(i), 2'b01, 5'(i));
      step();
      check("t3_valid", out_valid, 1);
      check("t3_src1", out_src1, 64'd100 + 64'(i));
      check("t3_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("t3_drained", out_valid, 0);
    check("t3_stall", stall_cnt, 0);

    // 4: illegal aluop encodings travel with their entry
    do_reset();
    out_ready = 1'b1;
    drive(64'h33, 0, 2'b11, 1);
    step();
    check("t4_op11_ill", out_illegal, 1);
    check("t4_op11_valid", out_valid, 1);
    check("t4_op11_src", out_src1, 64'h33);
    drive(64'h44, 0, 2'b10, 2);
    step();
    check("t4_op10_ill", out_illegal, 0);
    check("t4_op10_op", out_aluop, 2'b10);
    drive(64'h55, 0, 2'b00, 3);
    step();
    check("t4_op00_ill", out_illegal, 1);
    in_valid = 1'b0;
    step();

    // 5: flush from TWO and from ONE drops everything, including the push
    do_reset();
    drive(1, 1, 2'b01, 1);
    step();
    drive(2, 2, 2'b01, 2);
    step();
    check("t5_two", in_ready, 0);
    flush = 1'b1;
    drive(3, 3, 2'b01, 3);
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t5_fl_valid", out_valid, 0);
    check("t5_fl_ready", in_ready, 1);
    step();
    check("t5_dropped", out_valid, 0);
    out_ready = 1'b0;
    drive(4, 4, 2'b01, 4);
    step();
    check("t5_one", out_valid, 1);
    flush = 1'b1;
    drive(5, 5, 2'b01, 5);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t5_fl1_valid", out_valid, 0);
    step();
    check("t5_fl1_drop", out_valid, 0);

    // 6: stall counting, saturation on the 4-bit build, async reset mid-stall
    do_reset();
    drive(9, 9, 2'b01, 9);
    step();
    in_valid = 1'b0;
    check("t6_stall0", stall_cnt, 0);
    repeat (4) step();
    check("t6_stall4", stall_cnt, 4);
    check("t6_stall4_n4", stall_cnt4, 4);
    repeat (12) step();
    check("t6_stall16", stall_cnt, 16);
    check("t6_sat_f", stall_cnt4, 4'hF);
    repeat (3) step();
    check("t6_stall19", stall_cnt, 19);
    check("t6_sat_stick", stall_cnt4, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_stall", stall_cnt, 0);
    check("t6_rst_stall4", stall_cnt4, 0);
    check("t6_rst_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    check("t6_after_rst", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
